// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory request, skid buffer and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters (perf_fetched, perf_bubbles).
module fetch_stage #(
    parameter int unsigned            PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                if_id_valid,
    output logic [31:0]         if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc4,
    output logic [5:0]          opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles
`endif
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    state_t                r_state;
    logic                  r_req;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_if_valid;
    logic [31:0]           r_if_instr;
    logic [PC_WIDTH-1:0]   r_if_pc4;
    logic                  r_skid_vld;
    logic [31:0]           r_skid_instr;
    logic [PC_WIDTH-1:0]   r_skid_pc4;

    logic [PC_WIDTH-1:0]   w_pc4;
    logic                  w_flush;
    logic                  w_ld_valid;
    logic                  w_ld_bubble;

    assign w_pc4 = r_pc + PC_STEP;

    // Flush wins over stall and ack; BOOT ignores branches entirely.
    always_comb begin
        w_flush     = 1'b0;
        w_ld_valid  = 1'b0;
        w_ld_bubble = 1'b0;
        if (r_state != BOOT) begin
            w_flush     = branch_taken;
            w_ld_bubble = branch_taken ||
                          (r_state == FETCH && !imem_ack && !stall);
            w_ld_valid  = !branch_taken && !stall &&
                          ((r_state == FETCH && imem_ack) || r_state == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc4     <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
        end else begin
            if (w_ld_bubble) begin
                r_if_valid <= 1'b0;
                r_if_instr <= '0;
            end else if (w_ld_valid) begin
                if (r_state == HOLD) begin
                    r_if_valid <= r_skid_vld;
                    r_if_instr <= r_skid_instr;
                    r_if_pc4   <= r_skid_pc4;
                end else begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= imem_rdata;
                    r_if_pc4   <= w_pc4;
                end
            end

            case (r_state)
                BOOT: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: begin
                    if (w_flush) begin
                        r_pc <= branch_target;
                    end else if (imem_ack && !stall) begin
                        r_pc <= w_pc4;
                    end else if (imem_ack && stall) begin
                        r_skid_vld   <= 1'b1;
                        r_skid_instr <= imem_rdata;
                        r_skid_pc4   <= w_pc4;
                        r_state      <= HOLD;
                        r_req        <= 1'b0;
                    end
                end
                HOLD: begin
                    if (w_flush) begin
                        r_pc       <= branch_target;
                        r_skid_vld <= 1'b0;
                        r_state    <= FETCH;
                        r_req      <= 1'b1;
                    end else if (!stall) begin
                        r_pc       <= w_pc4;
                        r_skid_vld <= 1'b0;
                        r_state    <= FETCH;
                        r_req      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_ld_valid && r_perf_fetched != '1)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_ld_bubble && r_perf_bubbles != '1)
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign if_id_valid = r_if_valid;
    assign if_id_instr = r_if_instr;
    assign if_id_pc4   = r_if_pc4;
    assign opcode      = r_if_instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID entries queued at stimulus, popped after the edge.
module tb_fetch_stage;

    localparam int LOAD = 0;
    localparam int BUB  = 1;
    localparam int HLD  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_load = 0;
    int n_bub  = 0;

    logic [63:0] sb[$];
    logic        exp_v;
    logic [31:0] exp_i;
    logic [31:0] exp_p;

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .opcode        (opcode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'h2B, 10'h155, a[15:0] ^ 16'h5A00};
    endfunction

    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD00BAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Called at a negedge: check request, drive inputs, then check IF/ID after the edge.
    task automatic step(input logic a, input logic s, input logic b, input logic [31:0] tgt,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input int outcome, input logic [31:0] lpc);
        logic [63:0] e;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        if (outcome == LOAD) sb.push_back({mem_word(lpc), lpc + 32'd4});
        imem_ack      = a;
        stall         = s;
        branch_taken  = b;
        branch_target = tgt;
        @(posedge clk);
        #1;
        if (outcome == LOAD) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_v = 1'b1;
                exp_i = e[63:32];
                exp_p = e[31:0];
            end
            n_load++;
        end else if (outcome == BUB) begin
            exp_v = 1'b0;
            exp_i = '0;
            n_bub++;
        end
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, exp_v});
        chk("if_id_instr", if_id_instr, exp_i);
        chk("if_id_pc4", if_id_pc4, exp_p);
        chk("opcode", {26'd0, opcode}, {26'd0, exp_i[31:26]});
        @(negedge clk);
    endtask

    task automatic chk_cleared();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_ack = 1'b0;
        exp_v = 1'b0;
        exp_i = '0;
        exp_p = '0;
        repeat (2) @(negedge clk);
        chk_cleared();
        rst_n = 1'b1;

        step(0, 0, 0, 32'h0, 0, 32'h0, HLD, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h0, LOAD, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h4, LOAD, 32'h4);
        step(1, 0, 0, 32'h0, 1, 32'h8, LOAD, 32'h8);
        step(0, 0, 0, 32'h0, 1, 32'hC, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'hC, LOAD, 32'hC);
        step(0, 0, 0, 32'h0, 1, 32'h10, BUB, 32'h0);
        step(0, 0, 0, 32'h0, 1, 32'h10, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h10, LOAD, 32'h10);
        for (int unsigned k = 0; k < 3; k++)
            step(1, 0, 0, 32'h0, 1, 32'h14 + 4 * k, LOAD, 32'h14 + 4 * k);

        step(1, 1, 0, 32'h0, 1, 32'h20, HLD, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h0, HLD, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h0, HLD, 32'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0, LOAD, 32'h20);
        step(1, 0, 0, 32'h0, 1, 32'h24, LOAD, 32'h24);

        step(1, 1, 0, 32'h0, 1, 32'h28, HLD, 32'h0);
        step(0, 1, 0, 32'h0, 0, 32'h0, HLD, 32'h0);
        step(0, 1, 1, 32'h100, 0, 32'h0, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h100, LOAD, 32'h100);
        step(1, 0, 1, 32'hFFFF_FFF8, 1, 32'h104, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFF8, LOAD, 32'hFFFF_FFF8);
        step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, LOAD, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0, 1, 32'h0, BUB, 32'h0);
        step(1, 1, 1, 32'h40, 1, 32'h0, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h40, LOAD, 32'h40);
        step(0, 1, 0, 32'h0, 1, 32'h44, HLD, 32'h0);
        step(1, 1, 0, 32'h0, 1, 32'h44, HLD, 32'h0);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, n_load);
        chk("perf_bubbles", perf_bubbles, n_bub);
`endif

        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cleared();
        exp_v = 1'b0;
        exp_i = '0;
        exp_p = '0;
        n_load = 0;
        n_bub = 0;
        @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 1, 32'h200, 0, 32'h0, HLD, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h0, LOAD, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h4, LOAD, 32'h4);
        step(0, 0, 0, 32'h0, 1, 32'h8, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h8, LOAD, 32'h8);
        step(1, 0, 0, 32'h0, 1, 32'hC, LOAD, 32'hC);
        step(0, 0, 0, 32'h0, 1, 32'h10, BUB, 32'h0);
        step(1, 0, 0, 32'h0, 1, 32'h10, LOAD, 32'h10);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_5", perf_fetched, n_load);
        chk("perf_bubbles_2", perf_bubbles, n_bub);
`endif
        chk("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
